// File: rtl/lock_pkg.sv
// Shared types and defaults for the lock alarm sequencer.
package lock_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLASH   = 2'd1,
    LOCKOUT = 2'd2
  } state_e;

  localparam int MAX_FAILS_DEF   = 3;
  localparam int FLASH_SEC_DEF   = 12;
  localparam int LOCKOUT_SEC_DEF = 30;
  localparam int FAIL_W          = 4;
endpackage

// File: rtl/lock_alarm_ctrl_sec_timer.sv
// Loadable 8-bit seconds down-counter; done fires on the tick that takes it from 1 to 0.
module sec_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       tick,
  output logic [7:0] cnt,
  output logic       done
);
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                         cnt_d = 8'd0;
    else if (load)                   cnt_d = load_val;
    else if (tick && cnt_q != 8'd0)  cnt_d = cnt_q - 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign done = tick && (cnt_q == 8'd1);
endmodule

// File: rtl/lock_alarm_ctrl.sv
// Wrong-code counter and IDLE/FLASH/LOCKOUT sequencer driving the alarm flasher.
module lock_alarm_ctrl
  import lock_pkg::*;
#(
  parameter int MAX_FAILS   = MAX_FAILS_DEF,
  parameter int FLASH_SEC   = FLASH_SEC_DEF,
  parameter int LOCKOUT_SEC = LOCKOUT_SEC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_1hz,
  input  logic              verify_valid,
  input  logic              verify_ok,
  input  logic              admin_clear,
  input  logic              flash_done,
  output logic              flash_req,
  output logic              locked,
  output logic [FAIL_W-1:0] fail_count,
  output logic              unlock_pulse,
  output logic              reject_pulse,
  output logic [7:0]        lock_remaining
);
  localparam logic [FAIL_W-1:0] MAX_F = FAIL_W'(MAX_FAILS);

  state_e            state_q, state_d;
  logic [FAIL_W-1:0] fail_q, fail_d, fail_inc;
  logic              unlock_q, unlock_d, reject_q, reject_d;
  logic              flash_req_q, flash_req_d, locked_q, locked_d;
  logic              done_q;
  logic              flash_load, lock_load, tmr_clr;
  logic              flash_exp, lock_exp;
  logic [7:0]        flash_left, lock_left;

  assign fail_inc = (fail_q == {FAIL_W{1'b1}}) ? fail_q : fail_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    fail_d     = fail_q;
    unlock_d   = 1'b0;
    reject_d   = 1'b0;
    flash_load = 1'b0;
    lock_load  = 1'b0;
    tmr_clr    = 1'b0;
    if (admin_clear) begin
      state_d = IDLE;
      fail_d  = '0;
      tmr_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (verify_valid) begin
          if (verify_ok) begin
            unlock_d = 1'b1;
            fail_d   = '0;
          end else begin
            reject_d = 1'b1;
            if (fail_inc >= MAX_F) begin
              state_d    = FLASH;
              fail_d     = MAX_F;
              flash_load = 1'b1;
            end else begin
              fail_d = fail_inc;
            end
          end
        end
        FLASH: begin
          reject_d = verify_valid;
          // a watchdog that somehow was never armed must not trap us here
          if ((flash_done && !done_q) || flash_exp || flash_left == 8'd0) begin
            state_d   = LOCKOUT;
            lock_load = 1'b1;
          end
        end
        LOCKOUT: begin
          reject_d = verify_valid;
          if (lock_exp) begin
            state_d = IDLE;
            fail_d  = '0;
          end
        end
        default: begin
          state_d = IDLE;
          fail_d  = '0;
          tmr_clr = 1'b1;
        end
      endcase
    end
    flash_req_d = (state_d == FLASH);
    locked_d    = (state_d == FLASH) || (state_d == LOCKOUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      fail_q      <= '0;
      unlock_q    <= 1'b0;
      reject_q    <= 1'b0;
      flash_req_q <= 1'b0;
      locked_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fail_q      <= fail_d;
      unlock_q    <= unlock_d;
      reject_q    <= reject_d;
      flash_req_q <= flash_req_d;
      locked_q    <= locked_d;
      // continuous sampling: a sticky high level at FLASH entry is not an edge
      done_q      <= flash_done;
    end
  end

  sec_timer u_flash_tmr (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .load     (flash_load),
    .load_val (8'(FLASH_SEC)),
    .tick     (tick_1hz && state_q == FLASH),
    .cnt      (flash_left),
    .done     (flash_exp)
  );

  sec_timer u_lock_tmr (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .load     (lock_load),
    .load_val (8'(LOCKOUT_SEC)),
    .tick     (tick_1hz && state_q == LOCKOUT),
    .cnt      (lock_left),
    .done     (lock_exp)
  );

  assign flash_req      = flash_req_q;
  assign locked         = locked_q;
  assign fail_count     = fail_q;
  assign unlock_pulse   = unlock_q;
  assign reject_pulse   = reject_q;
  assign lock_remaining = lock_left;
endmodule

// File: tb/tb_lock_alarm_ctrl.sv
// Directed bench for lock_alarm_ctrl: vector table plus multi-cycle sequences.
module tb_lock_alarm_ctrl;
  logic       clk = 1'b0, rst = 1'b1;
  logic       tick_1hz = 1'b0, verify_valid = 1'b0, verify_ok = 1'b0;
  logic       admin_clear = 1'b0, flash_done = 1'b0;
  logic       flash_req, locked, unlock_pulse, reject_pulse;
  logic [3:0] fail_count;
  logic [7:0] lock_remaining;
  logic       u1_fr, u1_lk, u1_un, u1_rj;
  logic [3:0] u1_fc;
  logic [7:0] u1_rm;
  int         checks = 0, failures = 0;

  always #5 clk = ~clk;

  lock_alarm_ctrl dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .verify_valid(verify_valid),
    .verify_ok(verify_ok), .admin_clear(admin_clear), .flash_done(flash_done),
    .flash_req(flash_req), .locked(locked), .fail_count(fail_count),
    .unlock_pulse(unlock_pulse), .reject_pulse(reject_pulse),
    .lock_remaining(lock_remaining)
  );

  lock_alarm_ctrl #(.MAX_FAILS(1), .FLASH_SEC(2), .LOCKOUT_SEC(1)) dut1 (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .verify_valid(verify_valid),
    .verify_ok(verify_ok), .admin_clear(admin_clear), .flash_done(flash_done),
    .flash_req(u1_fr), .locked(u1_lk), .fail_count(u1_fc),
    .unlock_pulse(u1_un), .reject_pulse(u1_rj), .lock_remaining(u1_rm)
  );

  typedef struct {
    logic       vv, ok, tk, clr;
    logic       fr, lk;
    logic [3:0] fc;
    logic       un, rj;
    logic [7:0] rm;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(logic vv, logic ok, logic tk, logic clr, logic fr,
                              logic lk, logic [3:0] fc, logic un, logic rj, logic [7:0] rm);
    vec_t v;
    v.vv = vv; v.ok = ok; v.tk = tk; v.clr = clr;
    v.fr = fr; v.lk = lk; v.fc = fc; v.un = un; v.rj = rj; v.rm = rm;
    return v;
  endfunction

  task automatic chk(string nm, logic fr, logic lk, logic [3:0] fc, logic un,
                     logic rj, logic [7:0] rm);
    logic [15:0] act, exp;
    act = {flash_req, locked, fail_count, unlock_pulse, reject_pulse, lock_remaining};
    exp = {fr, lk, fc, un, rj, rm};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got fr=%b lk=%b fc=%0d un=%b rj=%b rm=%0d, want fr=%b lk=%b fc=%0d un=%b rj=%b rm=%0d",
               nm, flash_req, locked, fail_count, unlock_pulse, reject_pulse, lock_remaining,
               fr, lk, fc, un, rj, rm);
    end
  endtask

  task automatic step(logic vv, logic ok, logic tk, logic clr);
    verify_valid = vv; verify_ok = ok; tick_1hz = tk; admin_clear = clr;
    @(posedge clk); #1;
    verify_valid = 1'b0; verify_ok = 1'b0; tick_1hz = 1'b0; admin_clear = 1'b0;
  endtask

  initial begin
    tbl[0]  = mk(1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0,4'd0,1'b0,1'b0,8'd0);
    tbl[1]  = mk(1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,4'd1,1'b0,1'b1,8'd0);
    tbl[2]  = mk(1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,4'd1,1'b0,1'b0,8'd0);
    tbl[3]  = mk(1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,4'd2,1'b0,1'b1,8'd0);
    tbl[4]  = mk(1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,4'd0,1'b1,1'b0,8'd0);
    tbl[5]  = mk(1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,4'd1,1'b0,1'b1,8'd0);
    tbl[6]  = mk(1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,4'd2,1'b0,1'b1,8'd0);
    tbl[7]  = mk(1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,4'd2,1'b0,1'b0,8'd0);
    tbl[8]  = mk(1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,4'd3,1'b0,1'b1,8'd0);
    tbl[9]  = mk(1'b1,1'b1,1'b0,1'b0, 1'b1,1'b1,4'd3,1'b0,1'b1,8'd0);
    tbl[10] = mk(1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,4'd3,1'b0,1'b0,8'd0);

    repeat (2) @(posedge clk);
    #1 chk("reset_held", 1'b0,1'b0,4'd0,1'b0,1'b0,8'd0);
    rst = 1'b0;
    step(1'b0,1'b0,1'b0,1'b0);
    chk("after_reset", 1'b0,1'b0,4'd0,1'b0,1'b0,8'd0);

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].vv, tbl[i].ok, tbl[i].tk, tbl[i].clr);
      chk($sformatf("vec%0d", i), tbl[i].fr, tbl[i].lk, tbl[i].fc, tbl[i].un, tbl[i].rj, tbl[i].rm);
      if (i == 1) begin
        checks++;
        if ({u1_fr, u1_lk, u1_fc, u1_un, u1_rj} !== {1'b1, 1'b1, 4'd1, 1'b0, 1'b1}) begin
          failures++;
          $display("FAIL max1_first_wrong: got fr=%b lk=%b fc=%0d un=%b rj=%b, want 1 1 1 0 1",
                   u1_fr, u1_lk, u1_fc, u1_un, u1_rj);
        end
      end
    end

    // FLASH ends on a flash_done edge after 10 ticks total
    for (int i = 0; i < 9; i++) step(1'b0,1'b0,1'b1,1'b0);
    chk("flash_10_ticks", 1'b1,1'b1,4'd3,1'b0,1'b0,8'd0);
    flash_done = 1'b1;
    step(1'b0,1'b0,1'b0,1'b0);
    chk("done_edge_lockout", 1'b0,1'b1,4'd3,1'b0,1'b0,8'd30);
    for (int i = 1; i <= 29; i++) begin
      step(1'b0,1'b0,1'b1,1'b0);
      chk($sformatf("lock_tick%0d", i), 1'b0,1'b1,4'd3,1'b0,1'b0,8'(30 - i));
      if (i == 10) begin
        step(1'b1,1'b1,1'b0,1'b0);
        chk("ok_in_lockout", 1'b0,1'b1,4'd3,1'b0,1'b1,8'd20);
      end
    end
    step(1'b1,1'b1,1'b1,1'b0);
    chk("lockout_exit_with_entry", 1'b0,1'b0,4'd0,1'b0,1'b1,8'd0);

    // flash_done stays high: only the watchdog ends FLASH
    step(1'b1,1'b0,1'b0,1'b0);
    step(1'b1,1'b0,1'b0,1'b0);
    chk("sticky_wrong2", 1'b0,1'b0,4'd2,1'b0,1'b1,8'd0);
    step(1'b1,1'b0,1'b0,1'b0);
    chk("sticky_flash_entry", 1'b1,1'b1,4'd3,1'b0,1'b1,8'd0);
    for (int i = 0; i < 11; i++) step(1'b0,1'b0,1'b1,1'b0);
    chk("sticky_11_ticks", 1'b1,1'b1,4'd3,1'b0,1'b0,8'd0);
    step(1'b0,1'b0,1'b1,1'b0);
    chk("watchdog_12th", 1'b0,1'b1,4'd3,1'b0,1'b0,8'd30);
    for (int i = 0; i < 13; i++) step(1'b0,1'b0,1'b1,1'b0);
    chk("lock_at_17", 1'b0,1'b1,4'd3,1'b0,1'b0,8'd17);
    step(1'b0,1'b0,1'b0,1'b1);
    chk("admin_clear", 1'b0,1'b0,4'd0,1'b0,1'b0,8'd0);

    // async reset in the middle of LOCKOUT
    flash_done = 1'b0;
    step(1'b0,1'b0,1'b0,1'b0);
    for (int i = 0; i < 3; i++) step(1'b1,1'b0,1'b0,1'b0);
    flash_done = 1'b1;
    step(1'b0,1'b0,1'b0,1'b0);
    for (int i = 0; i < 13; i++) step(1'b0,1'b0,1'b1,1'b0);
    chk("pre_reset_17", 1'b0,1'b1,4'd3,1'b0,1'b0,8'd17);
    #2 rst = 1'b1;
    #1 chk("async_reset", 1'b0,1'b0,4'd0,1'b0,1'b0,8'd0);
    @(negedge clk); rst = 1'b0;
    step(1'b0,1'b0,1'b0,1'b0);
    chk("post_reset_idle", 1'b0,1'b0,4'd0,1'b0,1'b0,8'd0);
    step(1'b1,1'b0,1'b0,1'b0);
    chk("post_reset_wrong", 1'b0,1'b0,4'd1,1'b0,1'b1,8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
